// File: rtl/bfm_apb_slave_mem.sv
// APB3 slave memory model: word storage, programmable wait
// states and single-address error injection.
module bfm_apb_slave_mem #(
  parameter int AWIDTH       = 8,
  parameter int WAIT_DEFAULT = 0,
  parameter int TPD          = 1
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              load;
  logic              done;
  logic              commit;

  logic [AWIDTH-1:0] lat_idx;
  logic              lat_reg;
  logic [1:0]        lat_off;
  logic              lat_write;
  logic [31:0]       lat_rdata;
  logic              lat_err;

  logic [3:0]        waits;
  logic              err_en;
  logic [AWIDTH-1:0] err_idx;

  logic [31:0]       mem [DEPTH];

  logic [AWIDTH-1:0] dec_idx;
  logic              dec_reg;
  logic [1:0]        dec_off;
  logic [31:0]       dec_rdata;
  logic              dec_err;

  assign dec_idx = PADDR[AWIDTH+1:2];
  assign dec_reg = PADDR[AWIDTH+2];
  assign dec_off = PADDR[3:2];

  // Faulting accesses return zero data, so zero it at decode.
  always_comb begin
    dec_rdata = '0;
    dec_err   = 1'b0;
    if (!dec_reg) begin
      dec_err = err_en && (dec_idx == err_idx);
      if (!dec_err) begin
        dec_rdata = mem[dec_idx];
      end
    end else begin
      unique case (1'b1)
        (dec_off == 2'd0): begin
          dec_rdata[3:0] = waits;
        end
        (dec_off == 2'd1): begin
          dec_rdata[31]         = err_en;
          dec_rdata[AWIDTH-1:0] = err_idx;
        end
        default: begin
          dec_err = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_n = ACCESS;
          cnt_n   = waits;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_n = IDLE;
        end else if (PENABLE) begin
          if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
          end else begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign commit = done && lat_write && !lat_err;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state     <= IDLE;
      cnt       <= '0;
      waits     <= 4'(WAIT_DEFAULT);
      err_en    <= 1'b0;
      err_idx   <= '0;
      lat_idx   <= '0;
      lat_reg   <= 1'b0;
      lat_off   <= '0;
      lat_write <= 1'b0;
      lat_rdata <= '0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        lat_idx   <= dec_idx;
        lat_reg   <= dec_reg;
        lat_off   <= dec_off;
        lat_write <= PWRITE;
        lat_rdata <= dec_rdata;
        lat_err   <= dec_err;
      end
      if (commit && lat_reg) begin
        unique case (1'b1)
          (lat_off == 2'd0): begin
            waits <= PWDATA[3:0];
          end
          (lat_off == 2'd1): begin
            err_en  <= PWDATA[31];
            err_idx <= PWDATA[AWIDTH-1:0];
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge PCLK) begin
    if (PRESETN && commit && !lat_reg) begin
      mem[lat_idx] <= PWDATA;
    end
  end

  assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
  assign PSLVERR = PREADY && lat_err;
  assign PRDATA  = (state == ACCESS) ? lat_rdata : '0;

  // Output delay is not modelled in the synthesizable core.
  logic unused_ok;
  assign unused_ok = (^{PADDR[31:AWIDTH+3], PADDR[1:0]})
                   ^ (TPD < 0);

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Scoreboard bench for bfm_apb_slave_mem: driver pushes
// expectations, negedge monitor pops and compares.
module tb_bfm_apb_slave_mem;

  logic        clk;
  logic        presetn;
  logic        psel;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  bfm_apb_slave_mem #(
    .AWIDTH(8),
    .WAIT_DEFAULT(0),
    .TPD(1)
  ) dut (
    .PCLK(clk),
    .PRESETN(presetn),
    .PSEL(psel),
    .PADDR(paddr),
    .PWRITE(pwrite),
    .PENABLE(penable),
    .PWDATA(pwdata),
    .PRDATA(prdata),
    .PREADY(pready),
    .PSLVERR(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        rd;
    logic        err;
    int          waits;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   wcnt;
  int   checks;
  int   errors;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!presetn) begin
      wcnt = 0;
    end else if (psel && penable) begin
      if (pready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got 1 expected 0");
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.nm, "_err"}, 32'(pslverr), 32'(mon_e.err));
          chk({mon_e.nm, "_waits"}, wcnt, mon_e.waits);
          if (mon_e.rd) begin
            chk({mon_e.nm, "_rdata"}, prdata, mon_e.rdata);
          end
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Enter aligned to posedge+1; leaves at posedge+1 after the
  // completing edge so the next call can follow with no gap.
  task automatic xfer(input logic [31:0] a,
                      input logic        w,
                      input logic [31:0] d,
                      input logic [31:0] er,
                      input logic        ee,
                      input int          ew,
                      input string       nm);
    exp_t e;
    bit   ok;
    e.rdata = er;
    e.rd    = !w;
    e.err   = ee;
    e.waits = ew;
    e.nm    = nm;
    sb.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = w;
    pwdata  = d;
    @(posedge clk);
    #1 penable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (pready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no PREADY expected PREADY", nm);
      void'(sb.pop_back());
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int bidx[16] = '{0, 250, 17, 96, 128, 200, 31, 64,
                   99, 11, 180, 255, 42, 77, 150, 222};

  initial begin
    checks  = 0;
    errors  = 0;
    wcnt    = 0;
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(posedge clk);
    #1 presetn = 1'b1;
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    @(posedge clk);
    #1;

    xfer(32'h10, 1, 32'hDEADBEEF, 0, 0, 0, "zw_wr");
    xfer(32'h10, 0, 0, 32'hDEADBEEF, 0, 0, "zw_rd");
    idle();

    xfer(32'h14, 1, 32'hA5A50005, 0, 0, 0, "w5_wr");
    xfer(32'h400, 1, 32'd3, 0, 0, 0, "ctrl3_wr");
    xfer(32'h14, 0, 0, 32'hA5A50005, 0, 3, "w5_rd");
    xfer(32'h400, 0, 0, 32'd3, 0, 3, "ctrl3_rd");
    xfer(32'h400, 1, 32'd0, 0, 0, 3, "ctrl0_wr");
    idle();

    xfer(32'h1C, 1, 32'h0BADF00D, 0, 0, 0, "w7_init");
    xfer(32'h404, 1, 32'h80000007, 0, 0, 0, "erra_wr");
    xfer(32'h1C, 1, 32'h1234, 0, 1, 0, "w7_err_wr");
    xfer(32'h1C, 0, 0, 32'h0, 1, 0, "w7_err_rd");
    xfer(32'h404, 0, 0, 32'h80000007, 0, 0, "erra_rd");
    xfer(32'h404, 1, 32'h0, 0, 0, 0, "erra_clr");
    xfer(32'h1C, 0, 0, 32'h0BADF00D, 0, 0, "w7_keep");
    idle();

    xfer(32'h408, 0, 0, 32'h0, 1, 0, "unm_rd");
    xfer(32'h408, 1, 32'hFFFFFFFF, 0, 1, 0, "unm_wr2");
    xfer(32'h40C, 1, 32'hFFFFFFFF, 0, 1, 0, "unm_wr3");
    xfer(32'h400, 0, 0, 32'h0, 0, 0, "unm_ctrl");
    xfer(32'h404, 0, 0, 32'h0, 0, 0, "unm_erra");
    idle();

    psel    = 1'b1;
    penable = 1'b1;
    paddr   = 32'h10;
    pwrite  = 1'b0;
    @(negedge clk);
    chk("idle_pen_c1", 32'(pready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_pen_c2", 32'(pready), 32'd0);
    @(posedge clk);
    #1;
    idle();

    xfer(32'h20, 1, 32'h11111111, 0, 0, 0, "w8_init");
    xfer(32'h400, 1, 32'd5, 0, 0, 0, "ctrl5_wr");
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = 32'h20;
    pwrite  = 1'b1;
    pwdata  = 32'h22222222;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 presetn = 1'b0;
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("rstmid_pready", 32'(pready), 32'd0);
    chk("rstmid_prdata", prdata, 32'd0);
    @(posedge clk);
    #1 presetn = 1'b1;
    @(posedge clk);
    #1;
    xfer(32'h400, 0, 0, 32'd0, 0, 0, "rstmid_ctrl");
    xfer(32'h20, 0, 0, 32'h11111111, 0, 0, "rstmid_w8");
    idle();

    for (int i = 0; i < 16; i++) begin
      xfer(32'(bidx[i]) << 2, 1, 32'hC0DE0000 + 32'(i),
           0, 0, 0, "b2b_wr");
    end
    for (int j = 0; j < 16; j++) begin
      int i;
      i = (j * 5) % 16;
      xfer(32'(bidx[i]) << 2, 0, 0, 32'hC0DE0000 + 32'(i),
           0, 0, "b2b_rd");
    end
    idle();
    repeat (2) @(posedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
